// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader and the instruction memory.
// Holds the loader state encoding, the frame sync marker and the
// instruction memory geometry.
package cpu_pkg;

  localparam int IMEM_ADDR_W  = 4;
  localparam int IMEM_INSTR_W = 16;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_CHECK,
    S_DONE,
    S_ERR
  } load_state_t;

endpackage

// File: rtl/load_timer.sv
// Inter-byte idle timer for the program loader.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the count (a byte was accepted)
//   enable     : count this cycle (inside a frame, no byte accepted)
//   expired    : the current idle cycle is the TIMEOUT-th in a row
module load_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CW'(TIMEOUT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Asserted during the idle cycle that brings the count to TIMEOUT, so the
  // loader's registered error flag rises on that same edge.
  assign expired = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader. Receives a framed program
// (SYNC, count N, N big-endian 16-bit words, XOR checksum), writes the words
// sequentially into instruction memory and releases the CPU only after a
// complete, checksum-verified load.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   in_data/in_valid      : incoming byte stream
//   in_ready              : always 1, the loader never stalls the source
//   imem_we/waddr/wdata   : registered instruction memory write port
//   cpu_hold              : keep the CPU in reset
//   done / error          : outcome of the last load
//   loaded_count          : words written by the last frame
module prog_loader
  import cpu_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter int         ADDR_W    = IMEM_ADDR_W,
  parameter int         INSTR_W   = IMEM_INSTR_W,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         TIMEOUT   = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [4:0]         loaded_count
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  load_state_t        state, state_n;
  logic [7:0]         hi, hi_n;
  logic [7:0]         csum, csum_n;
  logic [ADDR_W-1:0]  ptr, ptr_n;
  logic [4:0]         nwords, nwords_n;
  logic               we_n, done_n, error_n, hold_n;
  logic [ADDR_W-1:0]  waddr_n;
  logic [INSTR_W-1:0] wdata_n;
  logic [4:0]         lcount_n;

  logic accept, restart, timed, expired;

  assign in_ready = 1'b1;
  assign accept   = in_valid && in_ready;
  assign restart  = accept && (in_data == SYNC_BYTE) &&
                    (state inside {S_IDLE, S_DONE, S_ERR});
  assign timed    = state inside {S_COUNT, S_HI, S_LO, S_CHECK};

  load_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (timed && !accept),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      hi           <= '0;
      csum         <= '0;
      ptr          <= '0;
      nwords       <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      loaded_count <= '0;
    end else begin
      state        <= state_n;
      hi           <= hi_n;
      csum         <= csum_n;
      ptr          <= ptr_n;
      nwords       <= nwords_n;
      imem_we      <= we_n;
      imem_waddr   <= waddr_n;
      imem_wdata   <= wdata_n;
      cpu_hold     <= hold_n;
      done         <= done_n;
      error        <= error_n;
      loaded_count <= lcount_n;
    end
  end

  always_comb begin
    state_n  = state;
    hi_n     = hi;
    csum_n   = csum;
    ptr_n    = ptr;
    nwords_n = nwords;
    we_n     = 1'b0;
    waddr_n  = imem_waddr;
    wdata_n  = imem_wdata;
    hold_n   = cpu_hold;
    done_n   = done;
    error_n  = error;
    lcount_n = loaded_count;

    if (restart) begin
      state_n  = S_COUNT;
      hold_n   = 1'b1;
      done_n   = 1'b0;
      error_n  = 1'b0;
      lcount_n = '0;
      ptr_n    = '0;
      csum_n   = '0;
    end else if (expired) begin
      state_n = S_ERR;
      error_n = 1'b1;
    end else if (accept) begin
      unique case (state)
        S_COUNT: begin
          if ((in_data != 8'd0) && (in_data <= DEPTH_B)) begin
            nwords_n = in_data[4:0];
            state_n  = S_HI;
          end else begin
            state_n = S_ERR;
            error_n = 1'b1;
          end
        end
        S_HI: begin
          hi_n    = in_data;
          csum_n  = csum ^ in_data;
          state_n = S_LO;
        end
        S_LO: begin
          we_n     = 1'b1;
          waddr_n  = ptr;
          wdata_n  = INSTR_W'({hi, in_data});
          csum_n   = csum ^ in_data;
          ptr_n    = ptr + ADDR_W'(1);
          lcount_n = loaded_count + 5'd1;
          state_n  = (lcount_n == nwords) ? S_CHECK : S_HI;
        end
        S_CHECK: begin
          if (in_data == csum) begin
            state_n = S_DONE;
            done_n  = 1'b1;
            hold_n  = 1'b0;
          end else begin
            state_n = S_ERR;
            error_n = 1'b1;
          end
        end
        default: ;  // IDLE/DONE/ERR discard non-sync bytes
      endcase
    end
  end

endmodule
